// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
// Shared types and constants for the RV32I multi-cycle control unit:
//   - state_t        : FSM states
//   - instr_class_t  : decoded instruction class
//   - alu_op_t       : aluCtrl encodings
//   - opcode and trapCause constants
//   - alu_from_funct3: funct3 (+ alternate bit) to ALU operation
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } instr_class_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TMO = 2'b10;

    // alt selects SUB over ADD and SRA over SRL (funct7[5] in RV32I).
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/core_instr_decode.sv
// ---------------------------------------------------------------------------
// core_instr_decode
// Purely combinational instruction decoder. Maps the instruction register to
// its class, ALU operation, ALU B-operand select and an illegal flag.
// Ports:
//   ir        in  32  instruction register
//   cls       out     instruction class (CLS_NONE when illegal)
//   alu_op    out  4  ALU operation
//   mux2_sel  out  1  0 = data2, 1 = immediate
//   branch_ne out  1  branch is bne (else beq)
//   illegal   out  1  instruction is outside the supported subset
// ---------------------------------------------------------------------------
module core_instr_decode
    import core_ctrl_pkg::*;
(
    input  logic [31:0]  ir,
    output instr_class_t cls,
    output alu_op_t      alu_op,
    output logic         mux2_sel,
    output logic         branch_ne,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Register and immediate fields are not needed to pick control signals.
    logic unused_fields;
    assign unused_fields = ^{ir[24:15], ir[11:7]};

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        cls       = CLS_NONE;
        alu_op    = ALU_ADD;
        mux2_sel  = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b1;
        case (opcode)
            OP_R: begin
                cls    = CLS_R;
                alu_op = alu_from_funct3(funct3, funct7[5]);
                // Only SUB and SRA have an alternate encoding.
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_I: begin
                cls      = CLS_I;
                mux2_sel = 1'b1;
                case (funct3)
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'h00);
                    end
                    3'b101: begin
                        alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        illegal = !((funct7 == 7'h00) || (funct7 == 7'h20));
                    end
                    default: begin
                        // Upper bits are immediate data here, never a function code.
                        alu_op  = alu_from_funct3(funct3, 1'b0);
                        illegal = 1'b0;
                    end
                endcase
            end
            OP_LOAD: begin
                cls      = CLS_LOAD;
                mux2_sel = 1'b1;
                illegal  = (funct3 != F3_WORD);
            end
            OP_STORE: begin
                cls      = CLS_STORE;
                mux2_sel = 1'b1;
                illegal  = (funct3 != F3_WORD);
            end
            OP_BRANCH: begin
                cls       = CLS_BRANCH;
                alu_op    = ALU_SUB;
                branch_ne = (funct3 == F3_BNE);
                illegal   = !((funct3 == F3_BEQ) || (funct3 == F3_BNE));
            end
            default: ;
        endcase
        if (illegal) begin
            cls = CLS_NONE;
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// core_ctrl_fsm
// Multi-cycle control unit for the RV32I datapath. Sequences each instruction
// through FETCH, DECODE, EXEC, MEM and WB; traps on illegal instructions and
// on data-memory timeout; counts retired instructions.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   instrIn  [31:0]        fetched instruction word
//   zero                   ALU zero flag
//   dAck                   data memory access complete
//   irEn, pcEn             instruction register load / PC update strobes
//   mux1Sel                PC source (0 = PC+4, 1 = branch target)
//   mux2Sel                ALU B operand (0 = data2, 1 = immediate)
//   mux3Sel                write-back source (0 = ALU, 1 = memory)
//   regWrite               register file write enable
//   memRead, memWrite      data memory requests, held through MEM
//   aluCtrl  [ALU_W-1:0]   ALU operation
//   trap, trapCause [1:0]  sticky fault flag and cause
//   instret  [31:0]        retired-instruction count
// ---------------------------------------------------------------------------
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 15
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instrIn,
    input  logic             zero,
    input  logic             dAck,
    output logic             irEn,
    output logic             pcEn,
    output logic             mux1Sel,
    output logic             mux2Sel,
    output logic             mux3Sel,
    output logic             regWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic [ALU_W-1:0] aluCtrl,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [31:0]      instret
);

    localparam int CNT_BITS = $clog2(MEM_TIMEOUT + 1);
    localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [31:0]        ir_q;
    instr_class_t       cls_q;
    logic               bne_q;
    logic [ALU_W-1:0]   alu_q;
    logic               mux2_q;
    logic [1:0]         cause_q;
    logic [31:0]        instret_q;
    logic [CNT_W-1:0]   tmo_q;

    instr_class_t dec_cls;
    alu_op_t      dec_alu;
    logic         dec_mux2;
    logic         dec_bne;
    logic         dec_illegal;

    logic ir_en, pc_en, mux1, mux3, reg_wr, mem_rd, mem_wr;
    logic tmo_hit;

    core_instr_decode u_decode (
        .ir        (ir_q),
        .cls       (dec_cls),
        .alu_op    (dec_alu),
        .mux2_sel  (dec_mux2),
        .branch_ne (dec_bne),
        .illegal   (dec_illegal)
    );

    assign tmo_hit = (state_q == MEM) && !dAck && (tmo_q == TMO_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            cls_q     <= CLS_NONE;
            bne_q     <= 1'b0;
            alu_q     <= '0;
            mux2_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                ir_q <= instrIn;
            end
            // Decode results are captured once and held until the next DECODE,
            // so aluCtrl/mux2Sel stay stable for the rest of the instruction.
            if (state_q == DECODE) begin
                if (dec_illegal) begin
                    cause_q <= CAUSE_ILLEGAL;
                end else begin
                    cls_q  <= dec_cls;
                    alu_q  <= ALU_W'(dec_alu);
                    mux2_q <= dec_mux2;
                    bne_q  <= dec_bne;
                end
            end
            if (state_q == EXEC) begin
                tmo_q <= '0;
            end else if ((state_q == MEM) && !dAck && (tmo_q != TMO_LIMIT)) begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
            if (tmo_hit) begin
                cause_q <= CAUSE_MEM_TMO;
            end
            // pcEn is asserted exactly once per retired instruction.
            if (pc_en) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        mux1    = 1'b0;
        mux3    = 1'b0;
        reg_wr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            FETCH: begin
                ir_en   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = dec_illegal ? TRAP : EXEC;
            end
            EXEC: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_en   = 1'b1;
                        mux1    = bne_q ? ~zero : zero;
                        state_d = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                mem_rd = (cls_q == CLS_LOAD);
                mem_wr = (cls_q == CLS_STORE);
                if (dAck) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = WB;
                    end else begin
                        // Store completes here; no write-back cycle.
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                reg_wr  = 1'b1;
                mux3    = (cls_q == CLS_LOAD);
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Combinational outputs are forced low while rst is high so no write or
    // request can escape after reset rises, even before the next edge.
    assign irEn      = ir_en  & ~rst;
    assign pcEn      = pc_en  & ~rst;
    assign mux1Sel   = mux1   & ~rst;
    assign mux3Sel   = mux3   & ~rst;
    assign regWrite  = reg_wr & ~rst;
    assign memRead   = mem_rd & ~rst;
    assign memWrite  = mem_wr & ~rst;
    assign mux2Sel   = mux2_q;
    assign aluCtrl   = alu_q;
    assign trap      = (state_q == TRAP);
    assign trapCause = cause_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl_fsm
// Directed per-cycle stimulus for core_ctrl_fsm. Each stimulus cycle pushes the
// hand-derived expected output word into a queue; a monitor on the falling
// edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_core_ctrl_fsm;

    typedef struct packed {
        logic        ir_en;
        logic        pc_en;
        logic        mux1;
        logic        mux2;
        logic        mux3;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [3:0]  alu;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] instret;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrIn = '0;
    logic        zero = 1'b0;
    logic        dAck = 1'b0;
    logic        irEn, pcEn, mux1Sel, mux2Sel, mux3Sel, regWrite, memRead, memWrite;
    logic [3:0]  aluCtrl;
    logic        trap;
    logic [1:0]  trapCause;
    logic [31:0] instret;

    core_ctrl_fsm #(.ALU_W(4), .MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .instrIn   (instrIn),
        .zero      (zero),
        .dAck      (dAck),
        .irEn      (irEn),
        .pcEn      (pcEn),
        .mux1Sel   (mux1Sel),
        .mux2Sel   (mux2Sel),
        .mux3Sel   (mux3Sel),
        .regWrite  (regWrite),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .aluCtrl   (aluCtrl),
        .trap      (trap),
        .trapCause (trapCause),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state carried between instructions.
    logic [3:0]  e_alu   = '0;
    logic        e_m2    = 1'b0;
    logic [31:0] e_cnt   = '0;
    logic        e_trap  = 1'b0;
    logic [1:0]  e_cause = '0;

    // Monitor: one output word per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {irEn, pcEn, mux1Sel, mux2Sel, mux3Sel, regWrite, memRead, memWrite,
                  aluCtrl, trap, trapCause, instret};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got ir=%b pc=%b m1=%b m2=%b m3=%b rw=%b mr=%b mw=%b alu=%0d trap=%b cause=%b instret=%0d ; want ir=%b pc=%b m1=%b m2=%b m3=%b rw=%b mr=%b mw=%b alu=%0d trap=%b cause=%b instret=%0d",
                         nm, a.ir_en, a.pc_en, a.mux1, a.mux2, a.mux3, a.reg_wr, a.mem_rd, a.mem_wr,
                         a.alu, a.trap, a.cause, a.instret,
                         e.ir_en, e.pc_en, e.mux1, e.mux2, e.mux3, e.reg_wr, e.mem_rd, e.mem_wr,
                         e.alu, e.trap, e.cause, e.instret);
            end
        end
    end

    function automatic obs_t ex(input logic ir, pc, m1, m3, rw, mr, mw);
        obs_t o;
        o.ir_en   = ir;
        o.pc_en   = pc;
        o.mux1    = m1;
        o.mux2    = e_m2;
        o.mux3    = m3;
        o.reg_wr  = rw;
        o.mem_rd  = mr;
        o.mem_wr  = mw;
        o.alu     = e_alu;
        o.trap    = e_trap;
        o.cause   = e_cause;
        o.instret = e_cnt;
        return o;
    endfunction

    task automatic step(input logic z, input logic d, input obs_t e, input string nm);
        zero = z;
        dAck = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst     = 1'b1;
        e_alu   = '0;
        e_m2    = 1'b0;
        e_cnt   = '0;
        e_trap  = 1'b0;
        e_cause = '0;
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".rst0"});
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".rst1"});
        rst = 1'b0;
    endtask

    // Front end shared by every instruction; dAck pulses here must be ignored.
    task automatic front(input logic [31:0] w, input logic z, input string nm);
        instrIn = w;
        step(z, 1, ex(1, 0, 0, 0, 0, 0, 0), {nm, ".fetch"});
        step(z, 1, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".decode"});
    endtask

    task automatic run_alu(input logic [31:0] w, input logic [3:0] alu, input logic m2, input string nm);
        front(w, 0, nm);
        e_alu = alu;
        e_m2  = m2;
        step(0, 1, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".exec"});
        step(0, 0, ex(0, 1, 0, 0, 1, 0, 0), {nm, ".wb"});
        e_cnt++;
    endtask

    task automatic run_branch(input logic [31:0] w, input logic z, input logic m1, input string nm);
        front(w, z, nm);
        e_alu = 4'd1;
        e_m2  = 1'b0;
        step(z, 0, ex(0, 1, m1, 0, 0, 0, 0), {nm, ".exec"});
        e_cnt++;
    endtask

    task automatic run_load(input logic [31:0] w, input int waits, input string nm);
        front(w, 0, nm);
        e_alu = 4'd0;
        e_m2  = 1'b1;
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".exec"});
        for (int i = 0; i < waits; i++) step(0, 0, ex(0, 0, 0, 0, 0, 1, 0), {nm, ".mem_wait"});
        step(0, 1, ex(0, 0, 0, 0, 0, 1, 0), {nm, ".mem_ack"});
        step(0, 0, ex(0, 1, 0, 1, 1, 0, 0), {nm, ".wb"});
        e_cnt++;
    endtask

    task automatic run_store(input logic [31:0] w, input string nm);
        front(w, 0, nm);
        e_alu = 4'd0;
        e_m2  = 1'b1;
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), {nm, ".exec"});
        step(0, 1, ex(0, 1, 0, 0, 0, 0, 1), {nm, ".mem_ack"});
        e_cnt++;
    endtask

    task automatic run_illegal(input logic [31:0] w, input string nm);
        front(w, 0, nm);
        e_trap  = 1'b1;
        e_cause = 2'b01;
        for (int i = 0; i < 22; i++)
            step(i[0], i[1], ex(0, 0, 0, 0, 0, 0, 0), {nm, ".trap"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("init");

        run_alu(32'h002081B3, 4'd0, 1'b0, "add");
        run_load(32'h0080A283, 3, "lw_wait3");
        run_store(32'h0050A623, "sw");
        run_branch(32'h00208463, 1'b1, 1'b1, "beq_z1");
        run_branch(32'h00208463, 1'b0, 1'b0, "beq_z0");
        run_alu(32'h402081B3, 4'd1, 1'b0, "sub");
        run_alu(32'h4030D293, 4'd7, 1'b1, "srai");
        run_branch(32'h00209463, 1'b0, 1'b1, "bne_z0");
        run_load(32'h0080A283, 0, "lw_wait0");

        // Load that never sees dAck: 16 request cycles, then a cause-10 trap.
        front(32'h0080A283, 0, "lw_tmo");
        e_alu = 4'd0;
        e_m2  = 1'b1;
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), "lw_tmo.exec");
        for (int i = 0; i < 16; i++) step(0, 0, ex(0, 0, 0, 0, 0, 1, 0), "lw_tmo.mem");
        e_trap  = 1'b1;
        e_cause = 2'b10;
        for (int i = 0; i < 22; i++) step(0, i[0], ex(0, 0, 0, 0, 0, 0, 0), "lw_tmo.trap");
        do_reset("after_tmo");

        // Reset raised in the middle of a memory request.
        front(32'h0080A283, 0, "lw_abort");
        e_alu = 4'd0;
        e_m2  = 1'b1;
        step(0, 0, ex(0, 0, 0, 0, 0, 0, 0), "lw_abort.exec");
        step(0, 0, ex(0, 0, 0, 0, 0, 1, 0), "lw_abort.mem");
        do_reset("abort");

        run_illegal(32'hFFFFFFFF, "ill_ffff");
        do_reset("after_ill");
        run_illegal(32'h022081B3, "ill_mul");
        do_reset("after_mul");
        run_alu(32'h002081B3, 4'd0, 1'b0, "add_again");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending words, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
